rom_arbiter: RTL and testbench

- Shares the single 32-word x 32-bit instruction/constant ROM between two requesters: port 0 (instruction fetch) and port 1 (data/constant load).
- Round-robin arbitration with one transaction in flight at a time.
- Waits out the fixed ROM read latency, then holds each result in a per-port response register until the requester takes it.
- Sits between the CPU core and the ROM instance. Drives the ROM address and reads the ROM q output.

---
 rtl/rom_arb_pkg.sv | 23 ++
 rtl/rom_arb_rsp_reg.sv | 45 ++++
 rtl/rom_arbiter.sv | 133 +++++++++++++
 tb/tb_rom_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
//==============================================================================
// Module   : rom_arb_pkg
// Brief    : Shared types and default sizes for the two-port ROM arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package rom_arb_pkg;

    localparam int C_DEF_M       = 32;
    localparam int C_DEF_ADDR_W  = 5;
    localparam int C_DEF_ROM_LAT = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef logic port_id_t;

endpackage

`default_nettype wire

// File: rtl/rom_arb_rsp_reg.sv
//==============================================================================
// Module   : rom_arb_rsp_reg
// Brief    : Per-port response holding register: captures a ROM word and holds
//            it until the requester takes it.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_arb_rsp_reg
    import rom_arb_pkg::*;
#(
    parameter int M = C_DEF_M
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         i_capture,
    input  logic [M-1:0] i_data,
    input  logic         i_rsp_ready,
    output logic         o_rsp_valid,
    output logic [M-1:0] o_rsp_data
);

    logic         r_valid;
    logic [M-1:0] r_data;

    // A capture only targets a port whose register is empty, so capture
    // and drain never coincide on the same instance.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_valid;
    assign o_rsp_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
//==============================================================================
// Module   : rom_arbiter
// Brief    : Round-robin arbiter sharing one fixed-latency ROM between an
//            instruction-fetch port and a data/constant-load port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int M       = C_DEF_M,
    parameter int ADDR_W  = C_DEF_ADDR_W,
    parameter int ROM_LAT = C_DEF_ROM_LAT
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [M-1:0]      p0_rsp_data,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [M-1:0]      p1_rsp_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [M-1:0]      rom_q,
    output logic              busy
);

    localparam logic [2:0] C_CNT_LOAD = 3'(ROM_LAT - 1);

    state_t            r_state;
    logic [2:0]        r_count;
    port_id_t          r_owner;
    port_id_t          r_last_grant;
    logic [ADDR_W-1:0] r_rom_address;
    logic              r_busy;

    logic w_idle, w_elig0, w_elig1, w_grant0, w_grant1;
    logic w_accept0, w_accept1, w_capture, w_cap0, w_cap1;

    // Eligibility looks only at the registered response flags, so a drain
    // on this edge does not let the same port issue on this edge.
    assign w_idle    = (r_state == IDLE);
    assign w_elig0   = !p0_rsp_valid;
    assign w_elig1   = !p1_rsp_valid;
    assign w_grant0  = !(p1_req_valid && w_elig1) || (r_last_grant == 1'b1);
    assign w_grant1  = !(p0_req_valid && w_elig0) || (r_last_grant == 1'b0);

    assign p0_req_ready = w_idle && w_elig0 && w_grant0;
    assign p1_req_ready = w_idle && w_elig1 && w_grant1;

    assign w_accept0 = p0_req_valid && p0_req_ready;
    assign w_accept1 = p1_req_valid && p1_req_ready;

    assign w_capture = (r_state == WAIT) && (r_count == 3'd0);
    assign w_cap0    = w_capture && (r_owner == 1'b0);
    assign w_cap1    = w_capture && (r_owner == 1'b1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_count       <= 3'd0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_rom_address <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept0) begin
                        r_rom_address <= p0_req_addr;
                        r_owner       <= 1'b0;
                        r_last_grant  <= 1'b0;
                        r_state       <= WAIT;
                        r_count       <= C_CNT_LOAD;
                        r_busy        <= 1'b1;
                    end else if (w_accept1) begin
                        r_rom_address <= p1_req_addr;
                        r_owner       <= 1'b1;
                        r_last_grant  <= 1'b1;
                        r_state       <= WAIT;
                        r_count       <= C_CNT_LOAD;
                        r_busy        <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_count == 3'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_address = r_rom_address;
    assign busy        = r_busy;

    rom_arb_rsp_reg #(.M(M)) u_rsp0 (
        .clock       (clock),
        .rst_n       (rst_n),
        .i_capture   (w_cap0),
        .i_data      (rom_q),
        .i_rsp_ready (p0_rsp_ready),
        .o_rsp_valid (p0_rsp_valid),
        .o_rsp_data  (p0_rsp_data)
    );

    rom_arb_rsp_reg #(.M(M)) u_rsp1 (
        .clock       (clock),
        .rst_n       (rst_n),
        .i_capture   (w_cap1),
        .i_data      (rom_q),
        .i_rsp_ready (p1_rsp_ready),
        .o_rsp_valid (p1_rsp_valid),
        .o_rsp_data  (p1_rsp_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
//==============================================================================
// Module   : tb_rom_arbiter
// Brief    : Self-checking bench for rom_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rom_arbiter;

    localparam int LAT = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;
    logic        p0_req_valid, p1_req_valid, p0_rsp_ready, p1_rsp_ready;
    logic [4:0]  p0_req_addr, p1_req_addr;
    logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, busy;
    logic [31:0] p0_rsp_data, p1_rsp_data, rom_q;
    logic [4:0]  rom_address;

    // Latency-sweep instances: only port 0 is exercised.
    logic        s1_req_valid, s1_rsp_ready, s4_req_valid, s4_rsp_ready;
    logic [4:0]  s1_req_addr, s4_req_addr, s1_rom_address, s4_rom_address;
    logic        s1_req_ready, s1_rsp_valid, s1_busy, s1_x_rdy, s1_x_vld;
    logic        s4_req_ready, s4_rsp_valid, s4_busy, s4_x_rdy, s4_x_vld;
    logic [31:0] s1_rsp_data, s4_rsp_data, s1_x_data, s4_x_data;
    logic [31:0] s1_rom_q, s4_rom_q, s4_q1, s4_q2, s4_q3;

    function automatic logic [31:0] romw(input logic [4:0] a);
        return 32'hC0DE_0000 | {27'd0, a};
    endfunction

    always @(posedge clock) rom_q <= romw(rom_address);
    assign s1_rom_q = romw(s1_rom_address);
    always @(posedge clock) begin
        s4_q1 <= romw(s4_rom_address);
        s4_q2 <= s4_q1;
        s4_q3 <= s4_q2;
    end
    assign s4_rom_q = s4_q3;

    rom_arbiter #(.M(32), .ADDR_W(5), .ROM_LAT(LAT)) dut (
        .clock(clock), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(p1_rsp_data),
        .rom_address(rom_address), .rom_q(rom_q), .busy(busy)
    );

    rom_arbiter #(.M(32), .ADDR_W(5), .ROM_LAT(1)) dut_l1 (
        .clock(clock), .rst_n(rst_n),
        .p0_req_valid(s1_req_valid), .p0_req_ready(s1_req_ready), .p0_req_addr(s1_req_addr),
        .p0_rsp_valid(s1_rsp_valid), .p0_rsp_ready(s1_rsp_ready), .p0_rsp_data(s1_rsp_data),
        .p1_req_valid(1'b0), .p1_req_ready(s1_x_rdy), .p1_req_addr(5'd0),
        .p1_rsp_valid(s1_x_vld), .p1_rsp_ready(1'b0), .p1_rsp_data(s1_x_data),
        .rom_address(s1_rom_address), .rom_q(s1_rom_q), .busy(s1_busy)
    );

    rom_arbiter #(.M(32), .ADDR_W(5), .ROM_LAT(4)) dut_l4 (
        .clock(clock), .rst_n(rst_n),
        .p0_req_valid(s4_req_valid), .p0_req_ready(s4_req_ready), .p0_req_addr(s4_req_addr),
        .p0_rsp_valid(s4_rsp_valid), .p0_rsp_ready(s4_rsp_ready), .p0_rsp_data(s4_rsp_data),
        .p1_req_valid(1'b0), .p1_req_ready(s4_x_rdy), .p1_req_addr(5'd0),
        .p1_rsp_valid(s4_x_vld), .p1_rsp_ready(1'b0), .p1_rsp_data(s4_x_data),
        .rom_address(s4_rom_address), .rom_q(s4_rom_q), .busy(s4_busy)
    );

    int n_checks, n_errors, cyc;

    // Model: one transaction in flight, finishing LAT edges after acceptance.
    bit          m_busy, m_last, m_owner, m_v0, m_v1;
    logic [4:0]  m_addr;
    logic [31:0] m_d0, m_d1;
    int          m_done;

    int          acc_port[$], acc_cyc[$];
    logic [31:0] got0[$], got1[$];
    bit          acc0_now, acc1_now;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        bit el0, el1, r0, r1, nv0, nv1;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_owner = 0; m_addr = 0;
            m_v0 = 0; m_v1 = 0; m_d0 = 0; m_d1 = 0;
        end
        el0 = !m_v0;
        el1 = !m_v1;
        r0  = !m_busy && el0 && (!(p1_req_valid && el1) || m_last);
        r1  = !m_busy && el1 && (!(p0_req_valid && el0) || !m_last);
        chk("p0_req_ready", {31'd0, p0_req_ready}, {31'd0, r0});
        chk("p1_req_ready", {31'd0, p1_req_ready}, {31'd0, r1});
        chk("p0_rsp_valid", {31'd0, p0_rsp_valid}, {31'd0, m_v0});
        chk("p1_rsp_valid", {31'd0, p1_rsp_valid}, {31'd0, m_v1});
        chk("p0_rsp_data", p0_rsp_data, m_d0);
        chk("p1_rsp_data", p1_rsp_data, m_d1);
        chk("rom_address", {27'd0, rom_address}, {27'd0, m_addr});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        acc0_now = 0;
        acc1_now = 0;
        if (rst_n) begin
            acc0_now = p0_req_valid && p0_req_ready;
            acc1_now = p1_req_valid && p1_req_ready;
            if (acc0_now) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
            if (acc1_now) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
            if (p0_rsp_valid && p0_rsp_ready) got0.push_back(p0_rsp_data);
            if (p1_rsp_valid && p1_rsp_ready) got1.push_back(p1_rsp_data);
            nv0 = m_v0 && !p0_rsp_ready;
            nv1 = m_v1 && !p1_rsp_ready;
            if (m_busy && cyc == m_done) begin
                if (m_owner) begin nv1 = 1; m_d1 = romw(m_addr); end
                else         begin nv0 = 1; m_d0 = romw(m_addr); end
                m_busy = 0;
            end else if (!m_busy && ((p0_req_valid && r0) || (p1_req_valid && r1))) begin
                m_owner = !(p0_req_valid && r0);
                m_addr  = m_owner ? p1_req_addr : p0_req_addr;
                m_last  = m_owner;
                m_busy  = 1;
                m_done  = cyc + LAT;
            end
            m_v0 = nv0;
            m_v1 = nv1;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        acc_port.delete(); acc_cyc.delete(); got0.delete(); got1.delete();
    endtask

    initial begin
        int bad, seen, i0, i1;
        n_checks = 0; n_errors = 0; cyc = 0;
        m_busy = 0; m_last = 1; m_owner = 0; m_addr = 0;
        m_v0 = 0; m_v1 = 0; m_d0 = 0; m_d1 = 0; m_done = 0;
        rst_n = 1;
        p0_req_valid = 0; p1_req_valid = 0; p0_rsp_ready = 0; p1_rsp_ready = 0;
        p0_req_addr = 0; p1_req_addr = 0;
        s1_req_valid = 0; s1_rsp_ready = 0; s1_req_addr = 0;
        s4_req_valid = 0; s4_rsp_ready = 0; s4_req_addr = 0;
        #2 rst_n = 0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rom_address", {27'd0, rom_address}, 0);
        chk("rst_p1_rsp_data", p1_rsp_data, 0);
        rst_n = 1;

        // Contention straight out of reset: port 0 wins the first tie.
        clear_log();
        p0_req_addr = 5'd1; p1_req_addr = 5'd2;
        p0_req_valid = 1; p1_req_valid = 1; p0_rsp_ready = 1; p1_rsp_ready = 1;
        for (int i = 0; i < 20 && !(got0.size() > 0 && got1.size() > 0); i++) begin
            tick();
            if (acc0_now) p0_req_valid = 0;
            if (acc1_now) p1_req_valid = 0;
        end
        chk("cont_nacc", acc_port.size(), 2);
        chk("cont_first", (acc_port.size() > 0) ? acc_port[0] : -1, 0);
        chk("cont_gap", (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1, 3);
        chk("cont_p0_data", (got0.size() > 0) ? got0[0] : 32'hx, 32'hC0DE_0001);
        chk("cont_p1_data", (got1.size() > 0) ? got1[0] : 32'hx, 32'hC0DE_0002);

        // Single read with a held response.
        p0_rsp_ready = 0; p1_rsp_ready = 0;
        p0_req_addr = 5'd5; p0_req_valid = 1;
        for (int i = 0; i < 10 && !acc0_now; i++) tick();
        p0_req_valid = 0;
        chk("sr_accept", {31'd0, acc0_now}, 1);
        chk("sr_rom_address", {27'd0, rom_address}, 5);
        tick();
        chk("sr_valid_t1", {31'd0, p0_rsp_valid}, 0);
        tick();
        chk("sr_valid_t2", {31'd0, p0_rsp_valid}, 1);
        chk("sr_data_t2", p0_rsp_data, 32'hC0DE_0005);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sr_hold_valid", {31'd0, p0_rsp_valid}, 1);
            chk("sr_hold_data", p0_rsp_data, 32'hC0DE_0005);
        end
        p0_rsp_ready = 1;
        tick();
        chk("sr_drained", {31'd0, p0_rsp_valid}, 0);

        // Reset one cycle after accepting addr 3: the read is dropped.
        p0_req_addr = 5'd3; p0_req_valid = 1;
        for (int i = 0; i < 10 && !acc0_now; i++) tick();
        p0_req_valid = 0;
        tick();
        rst_n = 0;
        #1;
        chk("mid_rst_valid", {31'd0, p0_rsp_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_addr", {27'd0, rom_address}, 0);
        tick();
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (p0_rsp_valid) seen++;
        end
        chk("mid_rst_noresp", seen, 0);

        // Both ports stream addresses 0..7.
        clear_log();
        i0 = 0; i1 = 0;
        p0_req_addr = 0; p1_req_addr = 0; p0_req_valid = 1; p1_req_valid = 1;
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        for (int i = 0; i < 200 && !(got0.size() == 8 && got1.size() == 8); i++) begin
            tick();
            if (acc0_now) begin
                i0++;
                if (i0 < 8) p0_req_addr = 5'(i0); else p0_req_valid = 0;
            end
            if (acc1_now) begin
                i1++;
                if (i1 < 8) p1_req_addr = 5'(i1); else p1_req_valid = 0;
            end
        end
        chk("rr_nacc", acc_port.size(), 16);
        bad = 0;
        for (int i = 1; i < acc_port.size(); i++) begin
            if (acc_port[i] == acc_port[i-1]) bad++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) bad++;
        end
        chk("rr_alternate", bad, 0);
        for (int i = 0; i < 8; i++) begin
            chk("rr_p0_word", (got0.size() > i) ? got0[i] : 32'hx, romw(5'(i)));
            chk("rr_p1_word", (got1.size() > i) ? got1[i] : 32'hx, romw(5'(i)));
        end

        // Backpressure on port 1 while port 0 keeps reading.
        p1_rsp_ready = 0;
        p1_req_addr = 5'd4; p1_req_valid = 1;
        for (int i = 0; i < 10 && !acc1_now; i++) tick();
        p1_req_valid = 0;
        for (int i = 0; i < 10 && !p1_rsp_valid; i++) tick();
        chk("bp_p1_data", p1_rsp_data, 32'hC0DE_0004);
        clear_log();
        p1_req_addr = 5'd9; p1_req_valid = 1;
        p0_req_addr = 5'd10; p0_req_valid = 1;
        bad = 0;
        for (int i = 0; i < 40 && got0.size() < 2; i++) begin
            tick();
            if (p1_req_ready) bad++;
            if (acc0_now) begin
                if (p0_req_addr == 5'd10) p0_req_addr = 5'd11;
                else p0_req_valid = 0;
            end
        end
        chk("bp_p1_stalled", bad, 0);
        chk("bp_p0_nacc", acc_port.size(), 2);
        // A single port re-issues only after its own drain edge.
        chk("bp_p0_gap", (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1, 4);
        chk("bp_p0_w10", (got0.size() > 0) ? got0[0] : 32'hx, 32'hC0DE_000A);
        chk("bp_p0_w11", (got0.size() > 1) ? got0[1] : 32'hx, 32'hC0DE_000B);
        p1_rsp_ready = 1;
        for (int i = 0; i < 10 && !acc1_now; i++) tick();
        chk("bp_p1_granted", {31'd0, acc1_now}, 1);
        p1_req_valid = 0;
        for (int i = 0; i < 20 && got1.size() < 2; i++) tick();
        chk("bp_p1_w4", (got1.size() > 0) ? got1[0] : 32'hx, 32'hC0DE_0004);
        chk("bp_p1_w9", (got1.size() > 1) ? got1[1] : 32'hx, 32'hC0DE_0009);

        // Latency sweep, ROM_LAT = 1 and 4, addr 31.
        s1_req_addr = 5'd31; s1_req_valid = 1;
        chk("l1_ready", {31'd0, s1_req_ready}, 1);
        tick();
        s1_req_valid = 0;
        chk("l1_early", {31'd0, s1_rsp_valid}, 0);
        tick();
        chk("l1_valid", {31'd0, s1_rsp_valid}, 1);
        chk("l1_data", s1_rsp_data, 32'hC0DE_001F);
        s4_req_addr = 5'd31; s4_req_valid = 1;
        chk("l4_ready", {31'd0, s4_req_ready}, 1);
        tick();
        s4_req_valid = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (s4_rsp_valid) seen++;
            tick();
        end
        chk("l4_early", seen, 0);
        chk("l4_valid", {31'd0, s4_rsp_valid}, 1);
        chk("l4_data", s4_rsp_data, 32'hC0DE_001F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
